// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: aligns Viterbi decoder output against the buffered clean
// transmit bits, counting compared bits, residual errors and per-window errors.
// Optional feature macro: BER_BURST_EN adds max_burst_o (longest mismatch run).
module viterbi_ber_checker #(
  parameter int DEPTH  = 64,
  parameter int SKIP   = 16,
  parameter int CNT_W  = 16,
  parameter int WIN    = 256,
  parameter int THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     ref_valid_i,
  input  logic                     ref_bit_i,
  input  logic                     dec_valid_i,
  input  logic                     dec_bit_i,
  output logic [1:0]               state_o,
  output logic [CNT_W-1:0]         bit_ct_o,
  output logic [CNT_W-1:0]         err_ct_o,
  output logic                     err_o,
  output logic [$clog2(WIN):0]     win_err_o,
  output logic                     win_done_o,
  output logic                     win_fail_o,
  output logic                     ovf_o,
  output logic                     unf_o
`ifdef BER_BURST_EN
  ,
  output logic [7:0]               max_burst_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WIN) + 1;
  localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, TRACK = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   skip_ct;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            mem [DEPTH];
  logic            full, empty, push, pop_req;
  logic            cmp_vld_p0, cmp_mis_p0, ovf_evt, unf_evt;
  logic [WW-1:0]   win_bits, win_errs, win_bits_nxt, win_errs_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign state_o = state;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign pop_req    = (state == TRACK) && dec_valid_i;
  assign cmp_vld_p0 = pop_req && !empty;
  assign cmp_mis_p0 = mem[rd_ptr[AW-1:0]] ^ dec_bit_i;
  assign push       = ref_valid_i && (!full || cmp_vld_p0);
  assign ovf_evt    = ref_valid_i && full && !cmp_vld_p0;
  assign unf_evt    = pop_req && empty;

  assign win_bits_nxt = win_bits + 1'b1;
  assign win_errs_nxt = win_errs + {{(WW-1){1'b0}}, cmp_mis_p0};

  // State register with clear returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          state <= IDLE;
    else if (clear_i) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state: warm-up is skipped entirely when SKIP is zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ref_valid_i) state_nxt = (SKIP == 0) ? TRACK : WARMUP;
      WARMUP:  if (dec_valid_i && (skip_ct == SW'(SKIP - 1))) state_nxt = TRACK;
      TRACK:   state_nxt = TRACK;
      default: state_nxt = IDLE;
    endcase
  end

  // Warm-up beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   skip_ct <= '0;
    else if (clear_i)                          skip_ct <= '0;
    else if ((state == WARMUP) && dec_valid_i) skip_ct <= skip_ct + 1'b1;
  end

  // Reference bit storage (data only, flushed via the pointers).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ref_bit_i;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + 1'b1;
      if (cmp_vld_p0) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- stage p0 -> p1: compare result registered into counters and window ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_ct_o   <= '0;
      err_ct_o   <= '0;
      err_o      <= 1'b0;
      win_bits   <= '0;
      win_errs   <= '0;
      win_err_o  <= '0;
      win_done_o <= 1'b0;
      win_fail_o <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
    end else if (clear_i) begin
      bit_ct_o   <= '0;
      err_ct_o   <= '0;
      err_o      <= 1'b0;
      win_bits   <= '0;
      win_errs   <= '0;
      win_err_o  <= '0;
      win_done_o <= 1'b0;
      win_fail_o <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
    end else begin
      err_o      <= 1'b0;
      win_done_o <= 1'b0;
      win_fail_o <= 1'b0;
      if (ovf_evt) ovf_o <= 1'b1;
      if (unf_evt) unf_o <= 1'b1;
      if (cmp_vld_p0) begin
        bit_ct_o <= sat_inc(bit_ct_o);
        if (cmp_mis_p0) begin
          err_ct_o <= sat_inc(err_ct_o);
          err_o    <= 1'b1;
        end
        if (win_bits_nxt == WW'(WIN)) begin
          win_err_o  <= win_errs_nxt;
          win_done_o <= 1'b1;
          win_fail_o <= (win_errs_nxt > WW'(THRESH));
          win_bits   <= '0;
          win_errs   <= '0;
        end else begin
          win_bits <= win_bits_nxt;
          win_errs <= win_errs_nxt;
        end
      end
    end
  end

`ifdef BER_BURST_EN
  logic [7:0] run_ct, run_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  assign run_nxt = sat_inc8(run_ct);

  // Longest mismatch run, updated alongside err_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_ct      <= '0;
      max_burst_o <= '0;
    end else if (clear_i) begin
      run_ct      <= '0;
      max_burst_o <= '0;
    end else if (cmp_vld_p0) begin
      if (cmp_mis_p0) begin
        run_ct <= run_nxt;
        if (run_nxt > max_burst_o) max_burst_o <= run_nxt;
      end else begin
        run_ct <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: table of error-injection streams plus
// hand-written overflow/underflow and clear-mid-window sequences.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0;
  logic        rst, clear_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i;
  logic [1:0]  state_o, s0_state;
  logic [15:0] bit_ct_o, err_ct_o, s0_bit_ct, s0_err_ct;
  logic        err_o, win_done_o, win_fail_o, ovf_o, unf_o;
  logic [8:0]  win_err_o, s0_win_err;
  logic        s0_err, s0_done, s0_fail, s0_ovf, s0_unf;
`ifdef BER_BURST_EN
  logic [7:0]  max_burst_o, s0_burst;
`endif

  always #5 clk = ~clk;

  viterbi_ber_checker #(.DEPTH(64), .SKIP(16), .CNT_W(16), .WIN(256), .THRESH(8)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .state_o(state_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .err_o(err_o),
    .win_err_o(win_err_o), .win_done_o(win_done_o), .win_fail_o(win_fail_o),
    .ovf_o(ovf_o), .unf_o(unf_o)
`ifdef BER_BURST_EN
    , .max_burst_o(max_burst_o)
`endif
  );

  viterbi_ber_checker #(.DEPTH(64), .SKIP(0), .CNT_W(16), .WIN(256), .THRESH(8)) dut_s0 (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .state_o(s0_state), .bit_ct_o(s0_bit_ct), .err_ct_o(s0_err_ct), .err_o(s0_err),
    .win_err_o(s0_win_err), .win_done_o(s0_done), .win_fail_o(s0_fail),
    .ovf_o(s0_ovf), .unf_o(s0_unf)
`ifdef BER_BURST_EN
    , .max_burst_o(s0_burst)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor, sampled on the falling edge.
  int n_errp = 0, n_done = 0, n_fail = 0, n_fail_alone = 0;
  int last_win_err = 0, bits_at_done = 0;
  always @(negedge clk) begin
    if (err_o) n_errp++;
    if (win_done_o) begin
      n_done++;
      last_win_err = int'(win_err_o);
      bits_at_done = int'(bit_ct_o);
    end
    if (win_fail_o) n_fail++;
    if (win_fail_o && !win_done_o) n_fail_alone++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ref_valid_i = 1'b0; ref_bit_i = 1'b0;
    dec_valid_i = 1'b0; dec_bit_i = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
  endtask

  logic [299:0] refbits;

  // 300 ref bits at cycles 0..299; 16 junk dec beats at cycles 4..19; then
  // dec bit i at cycle 20+i (lag of 20). Stops before cycle stop_c.
  task automatic run_stream(input logic [299:0] flips, input int stop_c);
    for (int c = 0; c < 330; c++) begin
      if (c == stop_c) break;
      ref_valid_i = (c < 300);
      ref_bit_i   = (c < 300) ? refbits[c] : 1'b0;
      dec_valid_i = (c >= 4) && (c < 320);
      if (c < 20) dec_bit_i = c[0];
      else        dec_bit_i = refbits[c-20] ^ flips[c-20];
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  typedef struct {
    logic [299:0] flips;
    int exp_err;
    int exp_win_err;
    int exp_fail;
    int exp_burst;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [299:0] m;
    int b_err, b_done, b_fail;

    for (int i = 0; i < 300; i++) refbits[i] = 1'($urandom_range(0, 1));

    m = '0;
    vecs[0] = '{m, 0, 0, 0, 0};
    m = '0; m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1; m[200] = 1'b1;
    vecs[1] = '{m, 4, 4, 0, 3};
    m = '0;
    for (int i = 1; i <= 9; i++) m[i*10] = 1'b1;
    vecs[2] = '{m, 9, 9, 1, 1};
    m = '0;
    for (int i = 250; i <= 258; i++) m[i] = 1'b1;
    vecs[3] = '{m, 9, 6, 0, 9};
    m = '0; m[255] = 1'b1; m[256] = 1'b1;
    vecs[4] = '{m, 2, 1, 0, 2};

    // Reset then idle.
    idle_inputs();
    clear_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reset_state", int'(state_o), 0);
    chk("reset_bit_ct", int'(bit_ct_o), 0);
    chk("reset_err_ct", int'(err_ct_o), 0);
    chk("reset_win_err", int'(win_err_o), 0);
    chk("reset_ovf", int'(ovf_o), 0);
    chk("reset_unf", int'(unf_o), 0);
    chk("reset_pulses", n_errp + n_done + n_fail, 0);

    // Overflow: 70 ref bits, no dec beats.
    for (int c = 0; c < 70; c++) begin
      ref_valid_i = 1'b1; ref_bit_i = c[0];
      tick();
    end
    idle_inputs();
    tick();
    chk("ovf_set", int'(ovf_o), 1);
    chk("ovf_state_warmup", int'(state_o), 1);
    chk("ovf_no_unf", int'(unf_o), 0);
    do_clear();
    chk("clear_ovf", int'(ovf_o), 0);
    chk("clear_state", int'(state_o), 0);

    // Underflow on the SKIP=0 instance.
    ref_valid_i = 1'b1; ref_bit_i = 1'b1;
    tick();
    chk("s0_track", int'(s0_state), 2);
    ref_valid_i = 1'b0; dec_valid_i = 1'b1; dec_bit_i = 1'b1;
    tick();
    chk("s0_first_cmp", int'(s0_bit_ct), 1);
    chk("s0_first_noerr", int'(s0_err_ct), 0);
    chk("s0_unf_before", int'(s0_unf), 0);
    tick();
    chk("s0_unf_set", int'(s0_unf), 1);
    chk("s0_unf_no_cmp", int'(s0_bit_ct), 1);
    ref_valid_i = 1'b1; ref_bit_i = 1'b0;
    tick();
    chk("s0_unf_push_no_cmp", int'(s0_bit_ct), 1);
    ref_valid_i = 1'b0; dec_bit_i = 1'b1;
    tick();
    chk("s0_stored_cmp", int'(s0_bit_ct), 2);
    chk("s0_stored_mis", int'(s0_err_ct), 1);
    do_clear();
    chk("s0_clear_unf", int'(s0_unf), 0);

    // Table-driven error-injection streams.
    for (int v = 0; v < 5; v++) begin
      do_clear();
      b_err = n_errp; b_done = n_done; b_fail = n_fail;
      run_stream(vecs[v].flips, 1000);
      chk($sformatf("v%0d_state", v), int'(state_o), 2);
      chk($sformatf("v%0d_bit_ct", v), int'(bit_ct_o), 300);
      chk($sformatf("v%0d_err_ct", v), int'(err_ct_o), vecs[v].exp_err);
      chk($sformatf("v%0d_err_pulses", v), n_errp - b_err, vecs[v].exp_err);
      chk($sformatf("v%0d_win_done", v), n_done - b_done, 1);
      chk($sformatf("v%0d_win_err_cap", v), last_win_err, vecs[v].exp_win_err);
      chk($sformatf("v%0d_win_err_hold", v), int'(win_err_o), vecs[v].exp_win_err);
      chk($sformatf("v%0d_bits_at_done", v), bits_at_done, 256);
      chk($sformatf("v%0d_win_fail", v), n_fail - b_fail, vecs[v].exp_fail);
      chk($sformatf("v%0d_ovf_unf", v), int'(ovf_o) + int'(unf_o), 0);
`ifdef BER_BURST_EN
      chk($sformatf("v%0d_max_burst", v), int'(max_burst_o), vecs[v].exp_burst);
`endif
    end
    chk("fail_without_done", n_fail_alone, 0);

    // clear_i mid-window at 100 compares.
    do_clear();
    b_done = n_done;
    run_stream('0, 120);
    chk("mid_bit_ct_100", int'(bit_ct_o), 100);
    do_clear();
    chk("mid_clear_bit_ct", int'(bit_ct_o), 0);
    chk("mid_clear_err_ct", int'(err_ct_o), 0);
    chk("mid_clear_state", int'(state_o), 0);
    chk("mid_clear_no_done", n_done - b_done, 0);
    b_done = n_done;
    run_stream('0, 1000);
    chk("resume_win_done", n_done - b_done, 1);
    chk("resume_bits_at_done", bits_at_done, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
